// File: rtl/decode_sched_if.sv
// Channel/engine bundle for the LZS decode job scheduler.
//   req        : per-channel job request (level, held until done/err)
//   eng_done   : engine done_o
//   eng_valid  : engine valid_o, one 16-bit output word this cycle
//   eng_getn   : engine m_src_getn, low = one 64-bit input word consumed
//   fo_full    : output FIFO full, engine legitimately stalled
//   grant      : one-hot engine owner, 0 when idle
//   src_sel    : source/dest mux select (0 = ch0, 1 = ch1)
//   eng_ce     : engine enable
//   eng_flush  : engine soft reset
//   busy       : job in progress
//   job_done   : one-cycle completion pulse per channel
//   job_err    : one-cycle timeout-error pulse per channel
//   in_cnt     : input words consumed by the current/last job
//   out_cnt    : output words produced by the current/last job
// master = scheduler side, slave = channel front-ends / engine side.
interface decode_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       req;
  logic             eng_done;
  logic             eng_valid;
  logic             eng_getn;
  logic             fo_full;
  logic [1:0]       grant;
  logic             src_sel;
  logic             eng_ce;
  logic             eng_flush;
  logic             busy;
  logic [1:0]       job_done;
  logic [1:0]       job_err;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    input  req, eng_done, eng_valid, eng_getn, fo_full,
    output grant, src_sel, eng_ce, eng_flush, busy, job_done, job_err,
           in_cnt, out_cnt
  );

  modport slave (
    output req, eng_done, eng_valid, eng_getn, fo_full,
    input  grant, src_sel, eng_ce, eng_flush, busy, job_done, job_err,
           in_cnt, out_cnt
  );
endinterface

// File: rtl/decode_sched.sv
// Job scheduler in front of the LZS decode engine. Arbitrates two channels
// round-robin onto the engine, sequences each job (select, enable, run,
// completion), counts input/output words and flushes the engine when the
// stall watchdog expires.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : decode_sched_if.master (request, engine status, grant/control,
//          completion pulses, word counters)
// All outputs are registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no job; waiting for any req
// GRANT   | owner selected, mux settling, engine still disabled
// RUN     | engine enabled; counting words, watchdog active
// DONE    | one cycle, job_done pulse to owner
// ERR     | engine held in soft reset for FLUSH_CYC cycles, job_err on last
module decode_sched #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TO_W      = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF,
  parameter int unsigned FLUSH_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  decode_sched_if.master bus
);

  localparam int unsigned     FL_W    = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [TO_W-1:0] WD_LOAD = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);
  localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYC - 1);
  localparam logic [FL_W-1:0] FL_ONE  = FL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             src_sel_q, src_sel_d;
  logic             eng_ce_q, eng_ce_d;
  logic             eng_flush_q, eng_flush_d;
  logic             busy_q, busy_d;
  logic [1:0]       job_done_q, job_done_d;
  logic [1:0]       job_err_q, job_err_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic             last_q, last_d;

  logic active;
  logic wd_expire;
  logic winner;

  // Any word moving in either direction proves the engine is alive.
  assign active = ~bus.eng_getn | bus.eng_valid;

  // Watchdog counts down the remaining quiet budget; the step from 1 is the
  // expiry, so a quiet non-stalled cycle at 1 is the TIMEOUT-th one.
  assign wd_expire = ~active & ~bus.fo_full & (wd_q == WD_ONE);

  // last_q is the channel served last; on contention the other one wins.
  assign winner = (bus.req == 2'b11) ? ~last_q : bus.req[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      src_sel_q   <= 1'b0;
      eng_ce_q    <= 1'b0;
      eng_flush_q <= 1'b0;
      busy_q      <= 1'b0;
      job_done_q  <= '0;
      job_err_q   <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wd_q        <= '0;
      fl_q        <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      src_sel_q   <= src_sel_d;
      eng_ce_q    <= eng_ce_d;
      eng_flush_q <= eng_flush_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
      job_err_q   <= job_err_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wd_q        <= wd_d;
      fl_q        <= fl_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req != 2'b00) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_RUN;
      ST_RUN: begin
        // Completion wins over a watchdog expiry on the same cycle.
        if (bus.eng_done)   state_d = ST_DONE;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   if (fl_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    src_sel_d   = src_sel_q;
    last_d      = last_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    wd_d        = wd_q;
    fl_d        = fl_q;
    job_done_d  = '0;
    job_err_d   = '0;
    eng_ce_d    = (state_d == ST_RUN);
    eng_flush_d = (state_d == ST_ERR);
    busy_d      = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_GRANT) begin
          grant_d   = winner ? 2'b10 : 2'b01;
          src_sel_d = winner;
          last_d    = winner;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wd_d      = WD_LOAD;
        end
      end
      ST_RUN: begin
        if (!bus.eng_getn && (in_cnt_q != '1))  in_cnt_d  = in_cnt_q + CNT_ONE;
        if (bus.eng_valid && (out_cnt_q != '1)) out_cnt_d = out_cnt_q + CNT_ONE;
        if (active)            wd_d = WD_LOAD;
        else if (!bus.fo_full) wd_d = wd_q - WD_ONE;
        if (state_d == ST_DONE) job_done_d = grant_q;
        if (state_d == ST_ERR) begin
          fl_d = FL_LOAD;
          if (FL_LOAD == '0) job_err_d = grant_q;
        end
      end
      ST_ERR: begin
        // fl_q counts flush cycles still to come after this one.
        if (fl_q != '0) begin
          fl_d = fl_q - FL_ONE;
          if (fl_q == FL_ONE) job_err_d = grant_q;
        end
      end
      default: ;
    endcase

    if (state_d == ST_IDLE) grant_d = '0;
  end

  assign bus.grant     = grant_q;
  assign bus.src_sel   = src_sel_q;
  assign bus.eng_ce    = eng_ce_q;
  assign bus.eng_flush = eng_flush_q;
  assign bus.busy      = busy_q;
  assign bus.job_done  = job_done_q;
  assign bus.job_err   = job_err_q;
  assign bus.in_cnt    = in_cnt_q;
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_decode_sched.sv
// Bench for decode_sched: directed scenarios followed by randomized engine
// traffic, every cycle compared against a job-level behavioural model.
module tb_decode_sched;

  localparam int CNT_W     = 4;
  localparam int TO_W      = 16;
  localparam int TIMEOUT   = 8;
  localparam int FLUSH_CYC = 4;
  localparam int SAT       = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_SETUP = 1;
  localparam int M_RUN   = 2;
  localparam int M_FIN   = 3;
  localparam int M_ABORT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_sched_if #(.CNT_W(CNT_W)) bus ();

  decode_sched #(
    .CNT_W(CNT_W),
    .TO_W(TO_W),
    .TIMEOUT(TIMEOUT),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who owns the engine, what phase the job is in,
  // how many quiet cycles have passed, how many flush cycles remain.
  int m_phase, m_owner, m_last, m_sel, m_in, m_out, m_quiet, m_flush_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_owner = -1; m_last = 1; m_sel = 0;
    m_in = 0; m_out = 0; m_quiet = 0; m_flush_left = 0;
  endtask

  task automatic model_edge();
    int w;
    if (!rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      M_IDLE: begin
        if (bus.req != 2'b00) begin
          if (bus.req == 2'b11) w = 1 - m_last;
          else                  w = bus.req[1] ? 1 : 0;
          m_owner = w; m_last = w; m_sel = w;
          m_in = 0; m_out = 0; m_quiet = 0;
          m_phase = M_SETUP;
        end
      end
      M_SETUP: m_phase = M_RUN;
      M_RUN: begin
        if (!bus.eng_getn) m_in = sat_inc(m_in);
        if (bus.eng_valid) m_out = sat_inc(m_out);
        if (!bus.eng_getn || bus.eng_valid) m_quiet = 0;
        else if (!bus.fo_full)              m_quiet++;
        if (bus.eng_done) m_phase = M_FIN;
        else if (m_quiet >= TIMEOUT) begin
          m_phase = M_ABORT;
          m_flush_left = FLUSH_CYC;
        end
      end
      M_FIN: begin
        m_phase = M_IDLE; m_owner = -1;
      end
      M_ABORT: begin
        if (m_flush_left == 1) begin
          m_phase = M_IDLE; m_owner = -1;
        end else m_flush_left--;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    chk("grant",     bus.grant,     eg);
    chk("src_sel",   bus.src_sel,   m_sel);
    chk("eng_ce",    bus.eng_ce,    m_phase == M_RUN);
    chk("eng_flush", bus.eng_flush, m_phase == M_ABORT);
    chk("busy",      bus.busy,      m_owner >= 0);
    chk("job_done",  bus.job_done,  (m_phase == M_FIN) ? eg : 2'b00);
    chk("job_err",   bus.job_err,   (m_phase == M_ABORT && m_flush_left == 1) ? eg : 2'b00);
    chk("in_cnt",    bus.in_cnt,    m_in);
    chk("out_cnt",   bus.out_cnt,   m_out);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_eng(input logic done, input logic valid, input logic getn, input logic full);
    bus.eng_done = done; bus.eng_valid = valid; bus.eng_getn = getn; bus.fo_full = full;
  endtask

  task automatic wait_ce(input string tag);
    int n;
    n = 0;
    while (!bus.eng_ce && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_ce_wait"}, bus.eng_ce, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    cycle();
    cycle();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [1:0] g_seq [3];
    int ce_cnt, fl_cnt, first_fl, err_at, err_val, done_cnt, err_cnt;
    int dens, p_get, p_val, p_full, p_done;

    g_seq[0] = 2'b01; g_seq[1] = 2'b10; g_seq[2] = 2'b01;
    bus.req = 2'b00;
    set_eng(1'b0, 1'b0, 1'b1, 1'b0);
    model_reset();

    // Reset state
    cycle();
    cycle();
    #2 rst = 1'b1;
    cycle();
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_ce",    bus.eng_ce, 1'b0);
    chk("rst_cnt",   {bus.in_cnt, bus.out_cnt}, 0);

    // Single job: 5 input words, 12 output words
    bus.req = 2'b01;
    cycle();
    chk("sj_grant", bus.grant, 2'b01);
    chk("sj_ce_early", bus.eng_ce, 1'b0);
    cycle();
    chk("sj_ce", bus.eng_ce, 1'b1);
    set_eng(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle();
    set_eng(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (12) cycle();
    set_eng(1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    set_eng(1'b0, 1'b0, 1'b1, 1'b0);
    bus.req = 2'b00;
    chk("sj_done", bus.job_done, 2'b01);
    chk("sj_in_cnt", bus.in_cnt, 5);
    chk("sj_out_cnt", bus.out_cnt, 12);
    cycle();
    chk("sj_done_pulse", bus.job_done, 2'b00);
    chk("sj_grant_rel", bus.grant, 2'b00);
    chk("sj_cnt_hold", bus.out_cnt, 12);
    cycle();

    // Contention: both channels held, served 0,1,0
    do_reset();
    bus.req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      wait_ce("ct");
      chk("ct_grant", bus.grant, g_seq[j]);
      chk("ct_src_sel", bus.src_sel, (j == 1) ? 1 : 0);
      bus.eng_done = 1'b1;
      cycle();
      bus.eng_done = 1'b0;
      chk("ct_done", bus.job_done, g_seq[j]);
    end
    bus.req = 2'b00;
    repeat (3) cycle();

    // Watchdog: silent engine on ch1
    bus.req = 2'b10;
    ce_cnt = 0; fl_cnt = 0; first_fl = -1; err_at = -1; err_val = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.eng_ce) ce_cnt++;
      if (bus.eng_flush) begin
        fl_cnt++;
        if (first_fl < 0) first_fl = i;
      end
      if (bus.job_err != 2'b00) begin
        err_at = i; err_val = bus.job_err; bus.req = 2'b00;
      end
      if (bus.job_done != 2'b00) done_cnt++;
    end
    chk("wd_run_cycles", ce_cnt, TIMEOUT);
    chk("wd_flush_cycles", fl_cnt, FLUSH_CYC);
    chk("wd_err_pos", err_at - first_fl, FLUSH_CYC - 1);
    chk("wd_err_val", err_val, 2'b10);
    chk("wd_no_done", done_cnt, 0);

    // Backpressure: 50 stalled cycles must not trip the watchdog
    bus.req = 2'b01;
    set_eng(1'b0, 1'b0, 1'b1, 1'b1);
    wait_ce("bp");
    repeat (50) cycle();
    chk("bp_no_flush", bus.eng_flush, 1'b0);
    set_eng(1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    set_eng(1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    set_eng(1'b0, 1'b0, 1'b1, 1'b0);
    bus.req = 2'b00;
    chk("bp_done", bus.job_done, 2'b01);
    chk("bp_out_cnt", bus.out_cnt, 1);
    repeat (2) cycle();

    // Done on the same cycle the watchdog would expire
    bus.req = 2'b01;
    wait_ce("sim");
    repeat (TIMEOUT - 1) cycle();
    bus.eng_done = 1'b1;
    cycle();
    bus.eng_done = 1'b0;
    bus.req = 2'b00;
    chk("sim_done", bus.job_done, 2'b01);
    chk("sim_err", bus.job_err, 2'b00);
    chk("sim_flush", bus.eng_flush, 1'b0);
    cycle();
    chk("sim_flush_after", bus.eng_flush, 1'b0);
    cycle();

    // Counter saturation
    bus.req = 2'b01;
    wait_ce("sat");
    set_eng(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) cycle();
    set_eng(1'b1, 1'b0, 1'b1, 1'b0);
    cycle();
    set_eng(1'b0, 1'b0, 1'b1, 1'b0);
    bus.req = 2'b00;
    chk("sat_out_cnt", bus.out_cnt, SAT);
    chk("sat_in_cnt", bus.in_cnt, SAT);
    chk("sat_done", bus.job_done, 2'b01);
    repeat (2) cycle();

    // Asynchronous reset in the middle of RUN
    bus.req = 2'b01;
    wait_ce("ar");
    bus.eng_getn = 1'b0;
    repeat (3) cycle();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("ar_grant", bus.grant, 2'b00);
    chk("ar_ce", bus.eng_ce, 1'b0);
    chk("ar_busy", bus.busy, 1'b0);
    chk("ar_in_cnt", bus.in_cnt, 0);
    compare_all();
    bus.req = 2'b00;
    bus.eng_getn = 1'b1;
    cycle();
    cycle();
    #2 rst = 1'b1;
    done_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bus.job_done != 2'b00) done_cnt++;
      if (bus.job_err != 2'b00) err_cnt++;
    end
    chk("ar_no_done", done_cnt, 0);
    chk("ar_no_err", err_cnt, 0);

    // Randomized traffic at varying activity densities
    for (int blk = 0; blk < 20; blk++) begin
      dens = $urandom_range(0, 2);
      case (dens)
        0:       begin p_get = 2;  p_val = 2;  p_full = 4; p_done = 16;  end
        1:       begin p_get = 8;  p_val = 8;  p_full = 4; p_done = 32;  end
        default: begin p_get = 32; p_val = 32; p_full = 2; p_done = 128; end
      endcase
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 7) == 0) bus.req = 2'($urandom_range(0, 3));
        bus.eng_getn  = ($urandom_range(0, p_get - 1) != 0);
        bus.eng_valid = ($urandom_range(0, p_val - 1) == 0);
        bus.fo_full   = ($urandom_range(0, p_full - 1) == 0);
        bus.eng_done  = ($urandom_range(0, p_done - 1) == 0);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
